// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular queue of {pc, inst}
// entries with a registered look-ahead stall back to fetch and a flush.

module fq_entry #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // Payload storage only; validity is tracked by the queue count.
  always_ff @(posedge clk) begin
    if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module fetch_queue #(
  parameter int DEPTH        = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int INST_WIDTH   = 32,
  parameter int STALL_MARGIN = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [INST_WIDTH-1:0]    in_data,
  output logic                     fetch_stall,
  input  logic                     id_ready,
  output logic                     out_valid,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [INST_WIDTH-1:0]    out_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [INST_WIDTH-1:0] inst;
  } fq_entry_t;

  localparam int EW = $bits(fq_entry_t);

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_stall, r_overflow;

  logic          w_empty, w_full, w_push, w_pop, w_drop;
  logic [CW-1:0] w_count_nxt;
  fq_entry_t     w_wr;
  fq_entry_t     w_head_ent;
  logic [EW-1:0] w_q [DEPTH];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && id_ready && !flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push  = in_valid && !flush && (!w_full || w_pop);
  assign w_drop  = in_valid && !flush && w_full && !w_pop;

  assign w_wr.addr = in_addr;
  assign w_wr.inst = in_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    fq_entry #(.W(EW)) u_ent (
      .clk  (clk),
      .i_we (w_push && (r_tail == PW'(g))),
      .i_d  (w_wr),
      .o_q  (w_q[g])
    );
  end

  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      // Stall is raised one entry early to absorb fetch's in-flight instruction.
      r_stall <= (w_count_nxt >= CW'(DEPTH - STALL_MARGIN));
      if (w_drop) r_overflow <= 1'b1;
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PW'(1);
        if (w_pop)  r_head <= r_head + PW'(1);
      end
    end
  end

  assign w_head_ent  = w_q[r_head];
  assign out_valid   = !w_empty;
  assign out_addr    = w_empty ? '0 : w_head_ent.addr;
  assign out_data    = w_empty ? '0 : w_head_ent.inst;
  assign fetch_stall = r_stall;
  assign count       = r_count;
  assign overflow    = r_overflow;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, STALL_MARGIN=1).

module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, id_ready, flush;
  logic [63:0] in_addr;
  logic [31:0] in_data;
  logic        fetch_stall, out_valid, overflow;
  logic [63:0] out_addr;
  logic [31:0] out_data;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(4), .ADDR_WIDTH(64), .INST_WIDTH(32), .STALL_MARGIN(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_addr(in_addr),
    .in_data(in_data), .fetch_stall(fetch_stall), .id_ready(id_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .flush(flush), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [31:0] d,
                       input logic rdy, input logic fl);
    in_valid = v; in_addr = a; in_data = d; id_ready = rdy; flush = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 64'h0, 32'h0, 0, 0);
    #2;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_stall", fetch_stall, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Fill: four pushes, decode not ready.
    drive(1, 64'h0, 32'h00000013, 0, 0);
    tick();
    chk("fill1_valid", out_valid, 1);
    chk("fill1_addr", out_addr, 64'h0);
    chk("fill1_data", out_data, 32'h00000013);
    chk("fill1_stall", fetch_stall, 0);
    drive(1, 64'h4, 32'h00100093, 0, 0);
    tick();
    chk("fill2_count", count, 2);
    chk("fill2_stall", fetch_stall, 0);
    drive(1, 64'h8, 32'h00200113, 0, 0);
    tick();
    chk("fill3_count", count, 3);
    chk("fill3_stall", fetch_stall, 1);
    drive(1, 64'hC, 32'h00300193, 0, 0);
    tick();
    chk("fill4_count", count, 4);
    chk("fill4_stall", fetch_stall, 1);
    chk("fill4_addr", out_addr, 64'h0);
    chk("fill4_data", out_data, 32'h00000013);
    chk("fill4_ovf", overflow, 0);

    // Overflow: push into full queue with no pop.
    drive(1, 64'h10, 32'hDEADBEEF, 0, 0);
    tick();
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_addr, 64'h0);

    // Simultaneous push/pop from full across a pointer wrap.
    for (int k = 0; k < 6; k++) begin
      drive(1, 64'h10 + 64'(4 * k), 32'hA000_0010 + 32'(4 * k), 1, 0);
      #1;
      chk($sformatf("pp%0d_addr", k), out_addr, 64'(4 * k));
      tick();
      chk($sformatf("pp%0d_count", k), count, 4);
    end
    chk("pp_stall", fetch_stall, 1);

    // Drain the remaining entries; 0x10 dropped on overflow must not show up here.
    for (int k = 0; k < 4; k++) begin
      drive(0, 64'h0, 32'h0, 1, 0);
      #1;
      chk($sformatf("dr%0d_addr", k), out_addr, 64'h18 + 64'(4 * k));
      chk($sformatf("dr%0d_data", k), out_data, 32'hA000_0018 + 32'(4 * k));
      tick();
    end
    chk("dr_count", count, 0);
    chk("dr_valid", out_valid, 0);
    chk("dr_stall", fetch_stall, 0);
    chk("dr_addr0", out_addr, 0);

    // Push into empty with id_ready high: no bypass, so no pop this cycle.
    drive(1, 64'h40, 32'h00000040, 1, 0);
    #1;
    chk("emp_pre_valid", out_valid, 0);
    tick();
    chk("emp_count", count, 1);
    chk("emp_valid", out_valid, 1);
    chk("emp_addr", out_addr, 64'h40);
    drive(0, 64'h0, 32'h0, 1, 0);
    tick();
    chk("emp_pop_count", count, 0);
    tick();
    chk("emp_idle_count", count, 0);
    chk("emp_idle_valid", out_valid, 0);

    // Flush with three entries and a push in flight.
    drive(1, 64'h50, 32'h50, 0, 0); tick();
    drive(1, 64'h54, 32'h54, 0, 0); tick();
    drive(1, 64'h58, 32'h58, 0, 0); tick();
    chk("fl_pre_count", count, 3);
    chk("fl_pre_stall", fetch_stall, 1);
    drive(1, 64'h80, 32'h80, 0, 1);
    tick();
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_stall", fetch_stall, 0);
    chk("fl_ovf_kept", overflow, 1);
    drive(1, 64'h200, 32'h0000_0200, 0, 0);
    tick();
    chk("fl_post_count", count, 1);
    chk("fl_post_addr", out_addr, 64'h200);
    chk("fl_post_data", out_data, 32'h0000_0200);

    // Async reset between edges with two entries held.
    drive(1, 64'h204, 32'h0000_0204, 0, 0);
    tick();
    drive(0, 64'h0, 32'h0, 0, 0);
    chk("ar_pre_count", count, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", out_valid, 0);
    chk("ar_stall", fetch_stall, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_addr", out_addr, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
